// File: rtl/width_packer.sv
// width_packer: gathers RATIO narrow words into one wide beat.
// Each accepted word goes into the next lane of a fill register. A word on the
// last lane, or a word flagged with i_in_last, closes the group. The closed beat
// is then moved into the output register. A new word can be accepted while the
// output beat is stalled, unless that word would close a group.
module width_packer #(
  parameter int D_WIDTH = 32,
  parameter int RATIO   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [D_WIDTH-1:0]         i_in_data,
  input  logic                       i_in_last,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [D_WIDTH*RATIO-1:0]   o_out_data,
  output logic [RATIO-1:0]           o_out_keep,
  output logic                       o_out_last,
  output logic                       o_pending
);

  localparam int LW = $clog2(RATIO);
  localparam int OW = D_WIDTH * RATIO;

  logic [LW-1:0] lane;
  logic [OW-1:0] fill;
  logic          closing;
  logic          accept;
  logic [OW-1:0] beat_data;
  logic [RATIO-1:0] beat_keep;

  // A word closes the group when it lands on the top lane or carries last.
  // o_in_ready is held low during reset.
  always_comb begin
    closing    = (lane == LW'(RATIO - 1)) | (i_in_valid & i_in_last);
    o_in_ready = !i_reset & (!closing | !o_out_valid | i_out_ready);
    accept     = i_in_valid & o_in_ready;
  end

  // Build the closing beat: fill register plus the current word at its lane.
  // Lanes above the current lane are already zero in the fill register.
  always_comb begin
    beat_data = fill;
    beat_data[lane*D_WIDTH +: D_WIDTH] = i_in_data;
    beat_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      beat_keep[k] = (LW'(k) <= lane);
    end
  end

  // Fill register and lane counter. Both return to zero only when a group closes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lane <= '0;
      fill <= '0;
    end else if (accept) begin
      if (closing) begin
        lane <= '0;
        fill <= '0;
      end else begin
        fill[lane*D_WIDTH +: D_WIDTH] <= i_in_data;
        lane <= lane + LW'(1);
      end
    end
  end

  // Output beat register. A closing accept loads a new beat, even in the same
  // cycle the old beat is consumed. Without a closing accept, consumption only
  // drops valid, and data, keep and last keep their values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_keep  <= '0;
      o_out_last  <= 1'b0;
    end else if (accept && closing) begin
      o_out_valid <= 1'b1;
      o_out_data  <= beat_data;
      o_out_keep  <= beat_keep;
      o_out_last  <= i_in_last;
    end else if (i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end

  // Words are still waiting in the fill register whenever the lane counter is nonzero.
  always_comb o_pending = (lane != '0);

endmodule

// File: tb/tb_width_packer.sv
// Scoreboard bench for width_packer (D_WIDTH=32, RATIO=4).
module tb_width_packer;

  localparam int DW = 32;
  localparam int R  = 4;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   k;
    logic         l;
  } beat_t;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_in_valid;
  logic         o_in_ready;
  logic [31:0]  i_in_data;
  logic         i_in_last;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [127:0] o_out_data;
  logic [3:0]   o_out_keep;
  logic         o_out_last;
  logic         o_pending;

  width_packer #(.D_WIDTH(DW), .RATIO(R)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .i_in_last   (i_in_last),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_out_keep  (o_out_keep),
    .o_out_last  (o_out_last),
    .o_pending   (o_pending)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stalls = 0;
  bit rnd_on = 1'b0;
  beat_t exp_q[$];
  int pop_cyc[$];
  beat_t mon_e;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [127:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.d = d; b.k = k; b.l = l;
    return b;
  endfunction

  // Monitor: compare every consumed beat against the head of the expected queue
  always @(negedge i_clk) begin
    if (!i_reset && o_out_valid && i_out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: got %h want none", o_out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_data", o_out_data, mon_e.d);
        chk("beat_keep", 128'(o_out_keep), 128'(mon_e.k));
        chk("beat_last", 128'(o_out_last), 128'(mon_e.l));
      end
      pop_cyc.push_back(cyc);
    end
  end

  // Present a word and wait (bounded) until it is accepted; returns at posedge+1
  task automatic send_word(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    i_in_valid = 1'b1; i_in_data = d; i_in_last = l;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge i_clk);
      if (o_in_ready === 1'b1) ok = 1'b1;
      else stalls++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: got ready=0 want ready=1 for word %h", d);
      i_in_valid = 1'b0;
    end else begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic idle(input int n);
    i_in_valid = 1'b0; i_in_last = 1'b0;
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] md;
    logic [3:0]   mkp;
    int           ml;
    logic [127:0] gd;
    logic [31:0]  w;
    logic         l;

    i_reset = 1'b1; i_in_valid = 1'b1; i_in_data = 32'hDEAD; i_in_last = 1'b0; i_out_ready = 1'b1;
    #2;
    chk("rst_valid",   128'(o_out_valid), 128'(0));
    chk("rst_data",    o_out_data, 128'(0));
    chk("rst_keep",    128'(o_out_keep), 128'(0));
    chk("rst_pending", 128'(o_pending), 128'(0));
    chk("rst_inready", 128'(o_in_ready), 128'(0));
    i_in_valid = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_reset = 1'b0;

    // Full group, downstream ready; first accept right after reset release
    stalls = 0;
    exp_q.push_back(mk(128'h00000044_00000033_00000022_00000011, 4'hF, 1'b0));
    send_word(32'h11, 1'b0);
    send_word(32'h22, 1'b0);
    send_word(32'h33, 1'b0);
    chk("pre_close_valid", 128'(o_out_valid), 128'(0));
    chk("pending_mid", 128'(o_pending), 128'(1));
    send_word(32'h44, 1'b0);
    chk("latency_valid", 128'(o_out_valid), 128'(1));
    chk("pending_after_close", 128'(o_pending), 128'(0));
    chk("no_stall_after_reset", 128'(stalls), 128'(0));
    idle(1);
    chk("drop_valid", 128'(o_out_valid), 128'(0));
    chk("hold_data", o_out_data, 128'h00000044_00000033_00000022_00000011);
    idle(1);

    // Early close with i_in_last on lane 1
    exp_q.push_back(mk(128'h0000000B_0000000A, 4'b0011, 1'b1));
    send_word(32'hA, 1'b0);
    chk("pending_after_A", 128'(o_pending), 128'(1));
    send_word(32'hB, 1'b1);
    chk("pending_after_B", 128'(o_pending), 128'(0));
    chk("early_keep", 128'(o_out_keep), 128'(4'b0011));
    idle(2);

    // Last on lane 0 and last on lane 3
    exp_q.push_back(mk(128'h55, 4'b0001, 1'b1));
    send_word(32'h55, 1'b1);
    chk("single_keep", 128'(o_out_keep), 128'(4'b0001));
    exp_q.push_back(mk(128'h00000064_00000063_00000062_00000061, 4'hF, 1'b1));
    send_word(32'h61, 1'b0);
    send_word(32'h62, 1'b0);
    send_word(32'h63, 1'b0);
    send_word(32'h64, 1'b1);
    chk("full_last", 128'(o_out_last), 128'(1));
    idle(2);

    // Output stall: non-closing words still go in, closing word waits
    i_out_ready = 1'b0;
    stalls = 0;
    exp_q.push_back(mk(128'h00000104_00000103_00000102_00000101, 4'hF, 1'b0));
    exp_q.push_back(mk(128'h00000204_00000203_00000202_00000201, 4'hF, 1'b0));
    send_word(32'h101, 1'b0);
    send_word(32'h102, 1'b0);
    send_word(32'h103, 1'b0);
    send_word(32'h104, 1'b0);
    send_word(32'h201, 1'b0);
    send_word(32'h202, 1'b0);
    send_word(32'h203, 1'b0);
    chk("stall_noclose_accepted", 128'(stalls), 128'(0));
    i_in_valid = 1'b1; i_in_data = 32'h204; i_in_last = 1'b0;
    @(negedge i_clk);
    chk("stall_inready_low", 128'(o_in_ready), 128'(0));
    repeat (3) @(negedge i_clk);
    chk("stall_data_stable", o_out_data, 128'h00000104_00000103_00000102_00000101);
    chk("stall_keep_stable", 128'(o_out_keep), 128'(4'hF));
    @(posedge i_clk); #1;
    i_out_ready = 1'b1;
    @(negedge i_clk);
    chk("release_inready", 128'(o_in_ready), 128'(1));
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    chk("no_bubble_valid", 128'(o_out_valid), 128'(1));
    chk("no_bubble_data", o_out_data, 128'h00000204_00000203_00000202_00000201);
    idle(2);

    // Continuous 16-word stream
    stalls = 0;
    pop_cyc.delete();
    gd = '0;
    for (int i = 0; i < 16; i++) begin
      w = 32'h1000 + 32'(i);
      gd[(i % 4)*32 +: 32] = w;
      if (i % 4 == 3) begin
        exp_q.push_back(mk(gd, 4'hF, 1'b0));
        gd = '0;
      end
      send_word(w, 1'b0);
    end
    idle(3);
    chk("stream_stalls", 128'(stalls), 128'(0));
    chk("stream_beats", 128'(pop_cyc.size()), 128'(4));
    if (pop_cyc.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("stream_spacing", 128'(pop_cyc[i] - pop_cyc[i-1]), 128'(4));

    // Reset mid-group with a beat pending
    i_out_ready = 1'b0;
    send_word(32'h301, 1'b0);
    send_word(32'h302, 1'b0);
    send_word(32'h303, 1'b0);
    send_word(32'h304, 1'b0);
    send_word(32'h305, 1'b0);
    send_word(32'h306, 1'b0);
    i_in_valid = 1'b0;
    chk("pre_rst_pending", 128'(o_pending), 128'(1));
    chk("pre_rst_valid", 128'(o_out_valid), 128'(1));
    #2 i_reset = 1'b1;
    #1;
    chk("arst_valid",   128'(o_out_valid), 128'(0));
    chk("arst_data",    o_out_data, 128'(0));
    chk("arst_keep",    128'(o_out_keep), 128'(0));
    chk("arst_last",    128'(o_out_last), 128'(0));
    chk("arst_pending", 128'(o_pending), 128'(0));
    chk("arst_inready", 128'(o_in_ready), 128'(0));
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    i_out_ready = 1'b1;
    stalls = 0;
    exp_q.push_back(mk(128'h77, 4'b0001, 1'b1));
    send_word(32'h77, 1'b1);
    chk("post_rst_first_accept", 128'(stalls), 128'(0));
    idle(2);

    // Randomised valid/ready/last against a reference packer model
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge i_clk); #1;
          i_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    md = '0; mkp = '0; ml = 0;
    for (int i = 0; i < 150; i++) begin
      w = $urandom;
      l = ($urandom_range(0, 4) == 0);
      if (i == 149 && ml != 0) l = 1'b1;
      md[ml*32 +: 32] = w;
      mkp[ml] = 1'b1;
      if (l || ml == 3) begin
        exp_q.push_back(mk(md, mkp, l));
        md = '0; mkp = '0; ml = 0;
      end else begin
        ml++;
      end
      send_word(w, l);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    i_in_valid = 1'b0;
    rnd_on = 1'b0;
    @(posedge i_clk); #2;
    i_out_ready = 1'b1;
    idle(6);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/width_packer.md
WIDTH_PACKER -- requirements
Module: width_packer

Interface
REQ-001 Parameter D_WIDTH, default 32, width of one input word.
REQ-002 Parameter RATIO, default 4, words per output beat; SHALL be a power of two, >= 2.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-high.
REQ-005 i_in_valid  input  1  upstream word valid (driven from FIFO o_slave_valid).
REQ-006 o_in_ready  output  1  word accepted this cycle when high with i_in_valid (drives FIFO i_slave_ready).
REQ-007 i_in_data  input  D_WIDTH  upstream word.
REQ-008 i_in_last  input  1  word closes the current group early.
REQ-009 o_out_valid  output  1  packed beat valid.
REQ-010 i_out_ready  input  1  downstream consumes beat when high with o_out_valid.
REQ-011 o_out_data  output  D_WIDTH*RATIO  packed beat; lane k = bits [k*D_WIDTH +: D_WIDTH].
REQ-012 o_out_keep  output  RATIO  bit k high = lane k holds a valid word.
REQ-013 o_out_last  output  1  beat was closed by i_in_last.
REQ-014 o_pending  output  1  fill register holds >= 1 word not yet packed.

Function
REQ-015 Accept = i_in_valid & o_in_ready; non-accepted words SHALL NOT change any state.
REQ-016 Lane counter, width $clog2(RATIO), SHALL select the lane written by each accepted word, starting at lane 0, incrementing by 1 per accept.
REQ-017 A word is "closing" when lane counter == RATIO-1 or i_in_last == 1.
REQ-018 Non-closing accepted word: written into fill register at current lane; counter += 1; o_pending = 1 from next cycle.
REQ-019 Closing accepted word: output register loads {fill register, current word} at next edge; o_out_keep = bits 0..lane set, others 0; unused lanes of o_out_data = 0; o_out_last = i_in_last; fill register and lane counter clear to 0.
REQ-020 Latency: closing word accepted at edge N -> o_out_valid = 1 in cycle after edge N.
REQ-021 o_in_ready = !closing | !o_out_valid | i_out_ready; combinational on i_in_valid-qualified i_in_last, lane counter, o_out_valid, i_out_ready.
REQ-022 Non-closing words SHALL be accepted even while output beat is stalled.
REQ-023 Output consumed with no closing accept same cycle: o_out_valid = 0 next cycle; data/keep/last hold last values.
REQ-024 Output consumed and closing word accepted same cycle: new beat loads, o_out_valid stays 1 (no bubble).
REQ-025 While o_out_valid & !i_out_ready, o_out_data, o_out_keep, o_out_last SHALL remain stable.
REQ-026 Sustained throughput: one word per cycle in, one beat per RATIO cycles out, when downstream always ready.
REQ-027 i_in_last on lane 0: single-word beat, keep = 1, last = 1.
REQ-028 i_in_last on lane RATIO-1: full beat, keep all ones, last = 1.
REQ-029 Lane counter wraps RATIO-1 -> 0 only via closing; no other wrap path.
REQ-030 o_pending = (lane counter != 0).

Reset
REQ-031 While i_reset = 1: o_out_valid = 0, o_out_data = 0, o_out_keep = 0, o_out_last = 0, o_pending = 0, lane counter = 0, fill register = 0, o_in_ready = 0.
REQ-032 Reset asserted mid-group SHALL discard partially filled words and any unconsumed output beat.
REQ-033 First accept possible in first cycle after i_reset deasserts.

Verification (D_WIDTH=32, RATIO=4)
REQ-034 Words 0x11,0x22,0x33,0x44 back-to-back, i_out_ready=1 -> one beat data 0x00000044_00000033_00000022_00000011, keep 4'b1111, last 0, one cycle after 4th accept.
REQ-035 Words 0xA,0xB with i_in_last on 0xB -> data 0x0000000B_0000000A in lanes 1:0, upper lanes 0, keep 4'b0011, last 1; o_pending 1 after 0xA, 0 after 0xB.
REQ-036 i_out_ready=0 with beat held, feed 8 words -> first 3 of second group accepted, o_in_ready=0 on 4th, beat stable; raise i_out_ready -> 4th accepted same cycle, second beat valid next cycle with no bubble.
REQ-037 Continuous stream 16 words, i_out_ready=1 -> 4 beats, in-ready never drops, beats 4 cycles apart.
REQ-038 Assert i_reset after 2 accepted words and with beat pending -> all outputs 0 asynchronously; next group after release starts at lane 0.
REQ-039 Randomised valid/ready with random i_in_last vs. reference model -> every accepted word appears exactly once, in order, correct lane and keep.
